// File: rtl/hash_word_pager_pkg.sv
// Shared page numbering and word geometry for the hash word pager.
package hash_word_pager_pkg;

    localparam int WORD_W     = 32;
    localparam int HASH_WORDS = 8;

    localparam logic [3:0] PAGE_NONCE = 4'd8;
    localparam logic [3:0] PAGE_COUNT = 4'd9;
    localparam logic [3:0] LAST_PAGE  = 4'd9;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw push-button; emits a one-cycle pulse
// on each accepted press.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync_0;
    logic             sync_1;
    logic             level_d;
    logic [CNT_W-1:0] count;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level, so any bounce back to the old level restarts the wait.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_0    <= 1'b0;
            sync_1    <= 1'b0;
            count     <= '0;
            btn_level <= 1'b0;
            level_d   <= 1'b0;
            btn_rise  <= 1'b0;
        end else begin
            sync_0  <= btn_raw;
            sync_1  <= sync_0;
            level_d <= btn_level;
            btn_rise <= btn_level & ~level_d;
            if (sync_1 == btn_level) begin
                count <= '0;
            end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_level <= sync_1;
                count     <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/hash_word_pager.sv
// Captures the latest miner result and pages through it one 32-bit word at
// a time for the seven-segment display driver.
module hash_word_pager
    import hash_word_pager_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_PAGES       = 10
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          hash_valid,
    input  logic [HASH_WORDS*WORD_W-1:0]  hash_data,
    input  logic [WORD_W-1:0]             nonce_data,
    input  logic                          freeze,
    input  logic                          btn_next_raw,
    input  logic                          btn_prev_raw,
    output logic [WORD_W-1:0]             Word,
    output logic [3:0]                    page_idx,
    output logic                          captured
);

    logic                         next_level;
    logic                         prev_level;
    logic                         next_p;
    logic                         prev_p;
    logic                         unused_levels;
    logic [HASH_WORDS*WORD_W-1:0] hash_reg;
    logic [WORD_W-1:0]            nonce_reg;
    logic [WORD_W-1:0]            result_count;
    logic [WORD_W-1:0]            hash_words [HASH_WORDS];
    logic [WORD_W-1:0]            word_sel;

    assign unused_levels = next_level ^ prev_level;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk_in    (clk_in),
        .reset     (reset),
        .btn_raw   (btn_next_raw),
        .btn_level (next_level),
        .btn_rise  (next_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk_in    (clk_in),
        .reset     (reset),
        .btn_raw   (btn_prev_raw),
        .btn_level (prev_level),
        .btn_rise  (prev_p)
    );

    // Word 0 is the most significant slice of the hash.
    always_comb begin
        for (int k = 0; k < HASH_WORDS; k++) begin
            hash_words[k] = hash_reg[(HASH_WORDS - 1 - k) * WORD_W +: WORD_W];
        end
    end

    always_comb begin
        word_sel = '0;
        if (page_idx < 4'(HASH_WORDS)) begin
            word_sel = hash_words[page_idx[2:0]];
        end else if (page_idx == PAGE_NONCE) begin
            word_sel = nonce_reg;
        end else if (page_idx == PAGE_COUNT) begin
            word_sel = result_count;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            hash_reg     <= '0;
            nonce_reg    <= '0;
            result_count <= '0;
            captured     <= 1'b0;
            page_idx     <= '0;
            Word         <= '0;
        end else begin
            Word <= word_sel;
            if (hash_valid && !freeze) begin
                hash_reg  <= hash_data;
                nonce_reg <= nonce_data;
                captured  <= 1'b1;
                if (result_count != '1) begin
                    result_count <= result_count + 32'd1;
                end
            end
            // Simultaneous presses cancel out.
            if (next_p && !prev_p) begin
                page_idx <= (page_idx == 4'(NUM_PAGES - 1)) ? 4'd0 : page_idx + 4'd1;
            end else if (prev_p && !next_p) begin
                page_idx <= (page_idx == 4'd0) ? LAST_PAGE : page_idx - 4'd1;
            end
        end
    end

endmodule

// File: doc/hash_word_pager.md
Name: hash_word_pager

Overview:
- Upstream feeder for the 8-digit seven-segment display driver.
- Captures the latest miner result: a 256-bit hash, its 32-bit nonce, and a running result count.
- Lets the user page through the capture 32 bits at a time using two debounced push-buttons.
- Drives the selected 32-bit word onto the display driver's Word input.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk_in cycles required to accept a button level change (10 ms at 100 MHz).
- NUM_PAGES, 10, number of pages: 8 hash words + nonce + count. Fixed at 10; other values are unsupported.

Ports:
- clk_in  input  1  board clock, 100 MHz, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- hash_valid  input  1  one-cycle strobe: hash_data/nonce_data valid this cycle.
- hash_data  input  256  result hash; bits [255:224] are word 0.
- nonce_data  input  32  nonce that produced hash_data.
- freeze  input  1  level; when high, hash_valid strobes are ignored.
- btn_next_raw  input  1  raw asynchronous button, active-high.
- btn_prev_raw  input  1  raw asynchronous button, active-high.
- Word  output  32  word selected for display.
- page_idx  output  4  current page, 0..NUM_PAGES-1.
- captured  output  1  sticky flag: at least one result captured since reset.

Behaviour:
- Reset (synchronous, clk_in edge with reset=1):
  - All capture registers, the count, page_idx, captured, Word, and debouncer state go to 0.
  - Debounced levels go to 0; no edge pulse is produced on the first cycle after reset.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter: counter clears whenever the synchronized level equals the current debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES-1 the debounced level takes the synchronized level and the counter clears.
  - Rising-edge detect on the debounced level gives a one-cycle pulse (next_p / prev_p).
  - Latency from a clean raw press to the pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles + 1 cycle.
  - Release is also debounced but produces no pulse.
- Paging (one page update per cycle):
  - next_p only: page_idx = page_idx+1, wrapping 9 -> 0.
  - prev_p only: page_idx = page_idx-1, wrapping 0 -> 9.
  - next_p and prev_p in the same cycle: page_idx unchanged.
- Capture: on hash_valid=1 and freeze=0, on the same edge:
  - hash_reg <= hash_data and nonce_reg <= nonce_data.
  - result_count increments, saturating at 32'hFFFF_FFFF.
  - captured <= 1.
  - page_idx is not altered; a capture and a page step in the same cycle both take effect.
- hash_valid with freeze=1: no register changes, count not incremented.
- Output mux, registered (Word updates 1 cycle after page_idx or capture registers change):
  - page k (0..7): hash_reg[255-32k -: 32].
  - page 8: nonce_reg.
  - page 9: result_count.
- captured clears only on reset.
- Reset asserted mid-debounce or mid-capture discards all in-flight state; no partial capture survives.
- Reset does not require the buttons to be released; a button held through reset is accepted as a new press only after a full debounce following reset deassertion.

Decomposition:
- Shared package constants: PAGE_NONCE=4'd8, PAGE_COUNT=4'd9, LAST_PAGE=4'd9, HASH_WORDS=8, WORD_W=32.
- One sub-module, button_debounce, instantiated twice:
  - ports clk_in, reset, btn_raw, btn_level, btn_rise.
  - parameter DEBOUNCE_CYCLES; counter width $clog2(DEBOUNCE_CYCLES).
- The top holds the capture registers, page counter, and output mux.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset, then idle 20 cycles -> Word=0, page_idx=0, captured=0, no page changes.
- hash_valid with hash_data = 256'h00000000_11111111_..._77777777 and nonce 32'hDEADBEEF -> page 0 Word=32'h00000000, captured=1. Step next to page 3 -> Word=32'h33333333. Page 8 -> 32'hDEADBEEF. Page 9 -> 32'h00000001.
- Press btn_next_raw cleanly for 10 cycles -> exactly one pulse, 7 cycles after press; page_idx 0->1. Bounce pattern 1,0,1,0 then steady 1 -> still exactly one increment.
- Wrap: at page 9 press next -> page_idx=0. At page 0 press prev -> page_idx=9, Word=result_count.
- Both buttons debounce-accept in the same cycle -> page_idx unchanged. hash_valid coincident with next_p -> page increments AND capture registers update.
- freeze=1 with 3 hash_valid strobes -> registers and count unchanged. Count preloaded to 32'hFFFFFFFF (by force), then a capture -> count stays 32'hFFFFFFFF. Reset asserted mid-debounce -> no pulse emitted, page_idx=0.
